alarm_sounder: RTL and testbench

- Parametrised alarm sounder for the alarm-clock datapath.
- Takes per-alarm match pulses from the time comparator, arbitrates among N_ALARMS channels and drives a gated square-wave buzzer.
- Beep pattern is on/off cadence; supports snooze with a count limit, explicit stop, and auto-timeout.
- Sits between the alarm-compare logic and the buzzer pin, with status outputs to the display block.

---
 rtl/alarm_pkg.sv | 22 ++
 rtl/alarm_sounder_tone_gen.sv | 75 +++++++
 rtl/alarm_sounder.sv | 141 ++++++++++++++
 tb/tb_alarm_sounder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state encoding and width helpers for the alarm sounder.
package alarm_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_t;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_sounder_tone_gen.sv
// Buzzer tone divider gated by the beep ON/OFF cadence; everything clears while run is low.
module tone_gen
  import alarm_pkg::*;
#(
  parameter int TONE_HALF_CYC = 25000,
  parameter int BEEP_ON_CYC   = 12500000,
  parameter int BEEP_OFF_CYC  = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic gated_tone
);

  localparam int TONE_W = clog2(TONE_HALF_CYC);
  localparam int BEEP_W = clog2(max2(BEEP_ON_CYC, BEEP_OFF_CYC));

  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic [BEEP_W-1:0] beep_end;
  logic              tone_q, tone_d;
  logic              beep_on_q, beep_on_d;
  logic              gated_q, gated_d;

  // The counters always describe the cycle about to be registered into
  // gated_q, so the first RING cycle shows phase 0 with the buzzer low.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    beep_cnt_d = beep_cnt_q;
    beep_on_d  = beep_on_q;
    beep_end   = beep_on_q ? BEEP_W'(BEEP_ON_CYC - 1) : BEEP_W'(BEEP_OFF_CYC - 1);
    gated_d    = run & tone_q & beep_on_q;
    if (!run) begin
      tone_cnt_d = '0;
      tone_d     = 1'b0;
      beep_cnt_d = '0;
      beep_on_d  = 1'b1;
    end else begin
      if (tone_cnt_q == TONE_W'(TONE_HALF_CYC - 1)) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
      end
      if (beep_cnt_q == beep_end) begin
        beep_cnt_d = '0;
        beep_on_d  = ~beep_on_q;
      end else begin
        beep_cnt_d = beep_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      beep_cnt_q <= '0;
      beep_on_q  <= 1'b1;
      gated_q    <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      beep_cnt_q <= beep_cnt_d;
      beep_on_q  <= beep_on_d;
      gated_q    <= gated_d;
    end
  end

  assign gated_tone = gated_q;

endmodule

// File: rtl/alarm_sounder.sv
// Alarm sounder top: channel arbitration, ring/snooze/timeout state machine and second counters.
module alarm_sounder
  import alarm_pkg::*;
#(
  parameter int N_ALARMS      = 2,
  parameter int TONE_HALF_CYC = 25000,
  parameter int BEEP_ON_CYC   = 12500000,
  parameter int BEEP_OFF_CYC  = 12500000,
  parameter int SEC_CYC       = 50000000,
  parameter int SNOOZE_S      = 300,
  parameter int TIMEOUT_S     = 600,
  parameter int MAX_SNOOZE    = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_ALARMS-1:0]              alarm_en,
  input  logic [N_ALARMS-1:0]              alarm_match,
  input  logic                             snooze,
  input  logic                             stop,
  output logic                             buzzer,
  output logic                             ringing,
  output logic                             snoozing,
  output logic [clog2(N_ALARMS)-1:0]       active_id,
  output logic [clog2(MAX_SNOOZE+1)-1:0]   snooze_cnt
);

  localparam int ID_W    = clog2(N_ALARMS);
  localparam int SNZ_W   = clog2(MAX_SNOOZE + 1);
  localparam int CYC_W   = clog2(SEC_CYC);
  localparam int SEC_MAX = max2(SNOOZE_S, TIMEOUT_S);
  localparam int SEC_W   = clog2(SEC_MAX + 1);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic [SNZ_W-1:0]   snooze_cnt_q, snooze_cnt_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic               ringing_q, snoozing_q;
  logic [N_ALARMS-1:0] req;
  logic [ID_W-1:0]    first_id;
  logic               sec_tick;
  logic               en_active;

  assign req       = alarm_match & alarm_en;
  assign sec_tick  = (cyc_q == CYC_W'(SEC_CYC - 1));
  assign en_active = alarm_en[active_id_q];

  always_comb begin
    first_id = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (req[i]) first_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    active_id_d  = active_id_q;
    snooze_cnt_d = snooze_cnt_q;
    cyc_d        = cyc_q;
    sec_d        = sec_q;
    if (state_q != S_IDLE) begin
      cyc_d = sec_tick ? '0 : cyc_q + 1'b1;
      if (sec_tick && sec_q != SEC_W'(SEC_MAX)) sec_d = sec_q + 1'b1;
    end
    // Priority in RING: stop/disable, then snooze, then timeout.
    unique case (state_q)
      S_IDLE: begin
        if (req != '0) begin
          state_d      = S_RING;
          active_id_d  = first_id;
          snooze_cnt_d = '0;
        end
      end
      S_RING: begin
        if (stop || !en_active) begin
          state_d = S_IDLE;
        end else if (snooze) begin
          if (snooze_cnt_q < SNZ_W'(MAX_SNOOZE)) begin
            state_d      = S_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (sec_tick && sec_q == SEC_W'(TIMEOUT_S - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_SNOOZE: begin
        if (stop || !en_active) begin
          state_d = S_IDLE;
        end else if (sec_tick && sec_q == SEC_W'(SNOOZE_S - 1)) begin
          state_d = S_RING;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      cyc_d = '0;
      sec_d = '0;
    end
    if (state_d == S_IDLE) snooze_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      active_id_q  <= '0;
      snooze_cnt_q <= '0;
      cyc_q        <= '0;
      sec_q        <= '0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_id_q  <= active_id_d;
      snooze_cnt_q <= snooze_cnt_d;
      cyc_q        <= cyc_d;
      sec_q        <= sec_d;
      ringing_q    <= (state_d == S_RING);
      snoozing_q   <= (state_d == S_SNOOZE);
    end
  end

  // Driving run from the next state keeps the tone aligned with ringing.
  tone_gen #(
    .TONE_HALF_CYC (TONE_HALF_CYC),
    .BEEP_ON_CYC   (BEEP_ON_CYC),
    .BEEP_OFF_CYC  (BEEP_OFF_CYC)
  ) u_tone_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (state_d == S_RING),
    .gated_tone (buzzer)
  );

  assign ringing    = ringing_q;
  assign snoozing   = snoozing_q;
  assign active_id  = active_id_q;
  assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_sounder.sv
// Scoreboard bench for alarm_sounder using short time constants.
module tb_alarm_sounder;

  localparam int N_ALARMS = 2;
  localparam int TONE_H   = 2;
  localparam int BEEP_ON  = 8;
  localparam int BEEP_OFF = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] alarm_en;
  logic [1:0] alarm_match;
  logic       snooze;
  logic       stop;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [0:0] active_id;
  logic [1:0] snooze_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string    tag;
    bit       ring;
    bit       snz;
    bit       id;
    bit [1:0] cnt;
    bit       buz;
    bit       chk_id;
  } exp_t;

  exp_t sb[$];

  alarm_sounder #(
    .N_ALARMS      (N_ALARMS),
    .TONE_HALF_CYC (TONE_H),
    .BEEP_ON_CYC   (BEEP_ON),
    .BEEP_OFF_CYC  (BEEP_OFF),
    .SEC_CYC       (10),
    .SNOOZE_S      (3),
    .TIMEOUT_S     (5),
    .MAX_SNOOZE    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alarm_en    (alarm_en),
    .alarm_match (alarm_match),
    .snooze      (snooze),
    .stop        (stop),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .active_id   (active_id),
    .snooze_cnt  (snooze_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference buzzer level in RING cycle k (k=0 is the first ringing cycle).
  function automatic bit buz_at(input int k);
    return (((k / TONE_H) % 2) == 1) && ((k % (BEEP_ON + BEEP_OFF)) < BEEP_ON);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input bit ring, input bit snz, input bit id,
                          input bit [1:0] cnt, input bit buz, input bit chk_id);
    exp_t e;
    e.tag = tag; e.ring = ring; e.snz = snz; e.id = id;
    e.cnt = cnt; e.buz = buz; e.chk_id = chk_id;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".ringing"}, int'(ringing), int'(e.ring));
      check({e.tag, ".snoozing"}, int'(snoozing), int'(e.snz));
      check({e.tag, ".snooze_cnt"}, int'(snooze_cnt), int'(e.cnt));
      check({e.tag, ".buzzer"}, int'(buzzer), int'(e.buz));
      if (e.chk_id) check({e.tag, ".active_id"}, int'(active_id), int'(e.id));
    end
  endtask

  task automatic exp_now(input string tag, input bit ring, input bit snz, input bit id,
                         input bit [1:0] cnt, input bit buz, input bit chk_id);
    push_exp(tag, ring, snz, id, cnt, buz, chk_id);
    drain();
  endtask

  task automatic start_ring(input logic [1:0] en, input logic [1:0] m);
    alarm_en = en; alarm_match = m;
    step(1);
    alarm_match = 2'b00;
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    exp_now(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; alarm_en = 2'b00; alarm_match = 2'b00; snooze = 1'b0; stop = 1'b0;
    step(2);
    exp_now("reset", 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    step(1);

    // Single alarm on channel 1; a stray match mid-ring must not disturb it.
    start_ring(2'b11, 2'b10);
    for (int k = 0; k < 32; k++) begin
      exp_now("s1_ring", 1, 0, 1, 0, buz_at(k), 1);
      if (k == 5) alarm_match = 2'b01;
      step(1);
      alarm_match = 2'b00;
    end
    do_stop("s1_stop");

    // Arbitration and enable masking.
    start_ring(2'b10, 2'b11);
    exp_now("s2_masked", 1, 0, 1, 0, 0, 1);
    do_stop("s2_stop_a");
    start_ring(2'b11, 2'b11);
    exp_now("s2_lowest", 1, 0, 0, 0, 0, 1);
    do_stop("s2_stop_b");
    start_ring(2'b00, 2'b11);
    for (int j = 0; j < 3; j++) begin
      exp_now("s2_disabled", 0, 0, 0, 0, 0, 0);
      step(1);
    end

    // Snooze, ignored second snooze, then re-ring with restarted cadence.
    start_ring(2'b11, 2'b01);
    step(3);
    snooze = 1'b1; step(1); snooze = 1'b0;
    for (int j = 0; j < 30; j++) begin
      exp_now("s3_snooze", 0, 1, 0, 1, 0, 1);
      if (j == 10) snooze = 1'b1;
      step(1);
      snooze = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      exp_now("s3_rering", 1, 0, 0, 1, buz_at(k), 1);
      step(1);
    end
    do_stop("s3_stop");

    // Snooze limit: third snooze acts as stop.
    start_ring(2'b11, 2'b01);
    for (int s = 1; s <= 2; s++) begin
      snooze = 1'b1; step(1); snooze = 1'b0;
      exp_now("s4_snooze", 0, 1, 0, 2'(s), 0, 1);
      step(30);
      exp_now("s4_rering", 1, 0, 0, 2'(s), 0, 1);
    end
    snooze = 1'b1; step(1); snooze = 1'b0;
    for (int j = 0; j < 35; j++) begin
      exp_now("s4_limit", 0, 0, 0, 0, 0, 0);
      step(1);
    end

    // Auto-timeout after 50 ringing cycles.
    start_ring(2'b11, 2'b10);
    for (int k = 0; k < 50; k++) begin
      exp_now("s5_ring", 1, 0, 1, 0, buz_at(k), 1);
      step(1);
    end
    exp_now("s5_timeout", 0, 0, 0, 0, 0, 0);

    // Stop beats snooze.
    start_ring(2'b11, 2'b01);
    step(2);
    stop = 1'b1; snooze = 1'b1; step(1); stop = 1'b0; snooze = 1'b0;
    exp_now("s5_stop_snooze", 0, 0, 0, 0, 0, 0);

    // Snooze beats timeout on the final ringing cycle; stop ends SNOOZE.
    start_ring(2'b11, 2'b01);
    step(49);
    snooze = 1'b1; step(1); snooze = 1'b0;
    exp_now("s5_snooze_timeout", 0, 1, 0, 1, 0, 1);
    do_stop("s5_stop_in_snooze");

    // Dropping the active channel's enable ends the event.
    start_ring(2'b11, 2'b01);
    step(4);
    alarm_en = 2'b10;
    step(1);
    exp_now("s5_disable", 0, 0, 0, 0, 0, 0);
    alarm_en = 2'b11;

    // Reset mid-SNOOZE discards the pending re-ring.
    start_ring(2'b11, 2'b10);
    snooze = 1'b1; step(1); snooze = 1'b0;
    exp_now("s6_snooze", 0, 1, 1, 1, 0, 1);
    step(5);
    rst_n = 1'b0; step(1);
    exp_now("s6_reset", 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    for (int j = 0; j < 40; j++) begin
      exp_now("s6_no_ring", 0, 0, 0, 0, 0, 1);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
